// File: rtl/cpu_control_sequencer.sv
// cpu_control_sequencer
// Multicycle control FSM for the 8-bit common-bus CPU. It decodes the
// instruction register and sequences fetch, decode, operand reads, execute
// and writeback over the single shared bus. It also counts retired
// instructions.
module cpu_control_sequencer #(
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [13:0]      instruction_register,
   input  logic             imem_ack,
   input  logic             a_zero,
   output logic             imem_req,
   output logic             ir_load_en,
   output logic             pc_load_en,
   output logic             pc_sel,
   output logic             rf_write_read,
   output logic [7:0]       rf_address,
   output logic             a_load_en,
   output logic             b_load_en,
   output logic             res_load_en,
   output logic [2:0]       alu_op,
   output logic [1:0]       bus_sel,
   output logic [7:0]       imm_out,
   output logic             halted,
   output logic [CNT_W-1:0] retired_count
);

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_READ_A    = 4'd2,
      S_READ_B    = 4'd3,
      S_EXEC      = 4'd4,
      S_WRITE     = 4'd5,
      S_WRITE_IMM = 4'd6,
      S_BRANCH    = 4'd7,
      S_HALT      = 4'd8
   } state_t;

   localparam logic [1:0] BUS_RF  = 2'd0;
   localparam logic [1:0] BUS_RES = 2'd1;
   localparam logic [1:0] BUS_IMM = 2'd2;

   state_t           r_state;
   state_t           w_state_next;
   logic [CNT_W-1:0] r_retired;
   logic             w_retire;

   // Instruction field extraction
   logic [3:0] w_opcode;
   logic [2:0] w_rd;
   logic [2:0] w_rs;
   logic [2:0] w_rt;
   logic       w_is_alu;
   logic       w_is_li;
   logic       w_is_beqz;
   logic       w_is_halt;

   assign w_opcode  = instruction_register[13:10];
   assign w_rd      = instruction_register[9:7];
   assign w_rs      = instruction_register[6:4];
   assign w_rt      = instruction_register[3:1];
   assign w_is_alu  = ~w_opcode[3];
   assign w_is_li   = (w_opcode == 4'h8);
   assign w_is_beqz = (w_opcode == 4'h9);
   assign w_is_halt = (w_opcode == 4'hF);

   // Combinational control outputs before reset gating
   logic       w_imem_req;
   logic       w_ir_load_en;
   logic       w_pc_load_en;
   logic       w_pc_sel;
   logic       w_rf_write;
   logic [7:0] w_rf_address;
   logic       w_a_load_en;
   logic       w_b_load_en;
   logic       w_res_load_en;
   logic [2:0] w_alu_op;
   logic [1:0] w_bus_sel;
   logic       w_halted;

   // State register and retired-instruction counter (synchronous active-low reset)
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state   <= S_FETCH;
         r_retired <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_retire) begin
            r_retired <= r_retired + CNT_W'(1);
         end
      end
   end

   // Next-state, retire flag and per-state control outputs
   always_comb begin
      w_state_next  = r_state;
      w_retire      = 1'b0;
      w_imem_req    = 1'b0;
      w_ir_load_en  = 1'b0;
      w_pc_load_en  = 1'b0;
      w_pc_sel      = 1'b0;
      w_rf_write    = 1'b0;
      w_rf_address  = 8'd0;
      w_a_load_en   = 1'b0;
      w_b_load_en   = 1'b0;
      w_res_load_en = 1'b0;
      w_alu_op      = 3'd0;
      w_bus_sel     = BUS_RF;
      w_halted      = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_imem_req   = 1'b1;
            w_ir_load_en = imem_ack;
            if (imem_ack) begin
               w_state_next = S_DECODE;
            end
         end
         S_DECODE: begin
            w_pc_load_en = 1'b1;
            w_pc_sel     = 1'b0;
            if (w_is_alu || w_is_beqz) begin
               w_state_next = S_READ_A;
            end else if (w_is_li) begin
               w_state_next = S_WRITE_IMM;
            end else if (w_is_halt) begin
               w_state_next = S_HALT;
            end else begin
               // NOP retires straight out of decode
               w_state_next = S_FETCH;
               w_retire     = 1'b1;
            end
         end
         S_READ_A: begin
            w_rf_address = {5'd0, w_rs};
            w_bus_sel    = BUS_RF;
            w_a_load_en  = 1'b1;
            w_state_next = w_is_beqz ? S_BRANCH : S_READ_B;
         end
         S_READ_B: begin
            w_rf_address = {5'd0, w_rt};
            w_bus_sel    = BUS_RF;
            w_b_load_en  = 1'b1;
            w_state_next = S_EXEC;
         end
         S_EXEC: begin
            w_alu_op      = w_opcode[2:0];
            w_res_load_en = 1'b1;
            w_state_next  = S_WRITE;
         end
         S_WRITE: begin
            w_rf_address = {5'd0, w_rd};
            w_bus_sel    = BUS_RES;
            w_rf_write   = 1'b1;
            w_state_next = S_FETCH;
            w_retire     = 1'b1;
         end
         S_WRITE_IMM: begin
            w_rf_address = {5'd0, w_rd};
            w_bus_sel    = BUS_IMM;
            w_rf_write   = 1'b1;
            w_state_next = S_FETCH;
            w_retire     = 1'b1;
         end
         S_BRANCH: begin
            w_pc_load_en = a_zero;
            w_pc_sel     = 1'b1;
            w_state_next = S_FETCH;
            w_retire     = 1'b1;
         end
         S_HALT: begin
            w_halted     = 1'b1;
            w_state_next = S_HALT;
         end
         default: begin
            w_state_next = S_FETCH;
         end
      endcase
   end

   // While reset is held every enable is forced low so an aborted
   // instruction can never write the register file in the reset cycle.
   always_comb begin
      imem_req      = 1'b0;
      ir_load_en    = 1'b0;
      pc_load_en    = 1'b0;
      pc_sel        = 1'b0;
      rf_write_read = 1'b0;
      rf_address    = 8'd0;
      a_load_en     = 1'b0;
      b_load_en     = 1'b0;
      res_load_en   = 1'b0;
      alu_op        = 3'd0;
      bus_sel       = BUS_RF;
      halted        = 1'b0;
      if (reset_n) begin
         imem_req      = w_imem_req;
         ir_load_en    = w_ir_load_en;
         pc_load_en    = w_pc_load_en;
         pc_sel        = w_pc_sel;
         rf_write_read = w_rf_write;
         rf_address    = w_rf_address;
         a_load_en     = w_a_load_en;
         b_load_en     = w_b_load_en;
         res_load_en   = w_res_load_en;
         alu_op        = w_alu_op;
         bus_sel       = w_bus_sel;
         halted        = w_halted;
      end
   end

   assign imm_out       = {1'b0, instruction_register[6:0]};
   assign retired_count = r_retired;

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// tb_cpu_control_sequencer
// Directed and randomized instruction streams checked cycle by cycle against
// a per-instruction-class micro-cycle table derived from the instruction set.
module tb_cpu_control_sequencer;

   localparam int TB_CNT_W = 8;

   logic                clock = 1'b0;
   logic                reset_n = 1'b0;
   logic [13:0]         instruction_register = 14'd0;
   logic                imem_ack = 1'b0;
   logic                a_zero = 1'b0;
   logic                imem_req;
   logic                ir_load_en;
   logic                pc_load_en;
   logic                pc_sel;
   logic                rf_write_read;
   logic [7:0]          rf_address;
   logic                a_load_en;
   logic                b_load_en;
   logic                res_load_en;
   logic [2:0]          alu_op;
   logic [1:0]          bus_sel;
   logic [7:0]          imm_out;
   logic                halted;
   logic [TB_CNT_W-1:0] retired_count;

   cpu_control_sequencer #(.CNT_W(TB_CNT_W)) dut (
      .clock                (clock),
      .reset_n              (reset_n),
      .instruction_register (instruction_register),
      .imem_ack             (imem_ack),
      .a_zero               (a_zero),
      .imem_req             (imem_req),
      .ir_load_en           (ir_load_en),
      .pc_load_en           (pc_load_en),
      .pc_sel               (pc_sel),
      .rf_write_read        (rf_write_read),
      .rf_address           (rf_address),
      .a_load_en            (a_load_en),
      .b_load_en            (b_load_en),
      .res_load_en          (res_load_en),
      .alu_op               (alu_op),
      .bus_sel              (bus_sel),
      .imm_out              (imm_out),
      .halted               (halted),
      .retired_count        (retired_count)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_pass   = 0;
   logic [TB_CNT_W-1:0] model_cnt = '0;
   logic [21:0] exp_q[$];

   wire [21:0] obs_ctl = {imem_req, ir_load_en, pc_load_en, pc_sel, rf_write_read,
                          rf_address, a_load_en, b_load_en, res_load_en,
                          alu_op, bus_sel, halted};

   function automatic logic [21:0] v(input logic req, input logic irl, input logic pcl,
                                     input logic pcs, input logic wr, input logic [7:0] addr,
                                     input logic al, input logic bl, input logic rl,
                                     input logic [2:0] op, input logic [1:0] bs,
                                     input logic h);
      return {req, irl, pcl, pcs, wr, addr, al, bl, rl, op, bs, h};
   endfunction

   localparam logic [21:0] V_ZERO  = 22'd0;
   localparam logic [21:0] V_IDLE  = 22'h200000;  // FETCH without ack: imem_req only
   localparam logic [21:0] V_HALT  = 22'h000001;  // halted only

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // One clock: inputs were set just after the previous edge; check, then advance.
   task automatic cyc(input string tag, input logic [21:0] exp);
      logic [7:0] exp_imm;
      #1;
      exp_imm = {1'b0, instruction_register[6:0]};
      chk({tag, "/ctl"}, 32'(obs_ctl), 32'(exp));
      chk({tag, "/imm"}, 32'(imm_out), 32'(exp_imm));
      chk({tag, "/cnt"}, 32'(retired_count), 32'(model_cnt));
      @(posedge clock);
      #1;
   endtask

   // Expected micro-cycles of one instruction, starting at its acknowledged fetch.
   task automatic plan(input logic [13:0] ir, input logic az);
      logic [3:0] op = ir[13:10];
      logic [7:0] rd = {5'd0, ir[9:7]};
      logic [7:0] rs = {5'd0, ir[6:4]};
      logic [7:0] rt = {5'd0, ir[3:1]};
      exp_q.delete();
      exp_q.push_back(v(1, 1, 0, 0, 0, 8'd0, 0, 0, 0, 3'd0, 2'd0, 0));   // fetch with ack
      exp_q.push_back(v(0, 0, 1, 0, 0, 8'd0, 0, 0, 0, 3'd0, 2'd0, 0));   // decode, pc+1
      if (op < 4'h8) begin
         exp_q.push_back(v(0, 0, 0, 0, 0, rs, 1, 0, 0, 3'd0, 2'd0, 0));
         exp_q.push_back(v(0, 0, 0, 0, 0, rt, 0, 1, 0, 3'd0, 2'd0, 0));
         exp_q.push_back(v(0, 0, 0, 0, 0, 8'd0, 0, 0, 1, op[2:0], 2'd0, 0));
         exp_q.push_back(v(0, 0, 0, 0, 1, rd, 0, 0, 0, 3'd0, 2'd1, 0));
      end else if (op == 4'h8) begin
         exp_q.push_back(v(0, 0, 0, 0, 1, rd, 0, 0, 0, 3'd0, 2'd2, 0));
      end else if (op == 4'h9) begin
         exp_q.push_back(v(0, 0, 0, 0, 0, rs, 1, 0, 0, 3'd0, 2'd0, 0));
         exp_q.push_back(v(0, 0, az, 1, 0, 8'd0, 0, 0, 0, 3'd0, 2'd0, 0));
      end
   endtask

   task automatic run_instr(input string tag, input logic [13:0] ir, input logic az,
                            input int stall);
      for (int s = 0; s < stall; s++) begin
         imem_ack = 1'b0;
         a_zero = 1'($urandom);
         instruction_register = 14'($urandom);
         cyc({tag, "/stall"}, V_IDLE);
      end
      plan(ir, az);
      instruction_register = ir;
      a_zero = az;
      for (int i = 0; i < exp_q.size(); i++) begin
         imem_ack = (i == 0) ? 1'b1 : 1'($urandom);
         cyc($sformatf("%s/c%0d", tag, i), exp_q[i]);
      end
      imem_ack = 1'b0;
      if (ir[13:10] != 4'hF) model_cnt = model_cnt + 1'b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL timeout simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [13:0] ir;
      logic [3:0]  op;

      // Reset: everything low while held, counter cleared.
      reset_n = 1'b0;
      @(posedge clock);
      @(posedge clock);
      #1;
      cyc("reset", V_ZERO);
      reset_n = 1'b1;

      // FETCH stall: imem_req held, no IR load, no progress.
      for (int i = 0; i < 5; i++) begin
         imem_ack = 1'b0;
         cyc("fetch_stall", V_IDLE);
      end

      // ADD r3 = r1 + r2, ack on first fetch cycle.
      run_instr("add", 14'h0194, 1'b0, 0);
      cyc("add_next_fetch", V_IDLE);

      // LI r7, 0x55
      run_instr("li", 14'h23D5, 1'b0, 0);
      cyc("li_next_fetch", V_IDLE);

      // BEQZ taken and not taken (rs = 2)
      run_instr("beqz_t", 14'h2420, 1'b1, 1);
      run_instr("beqz_nt", 14'h2420, 1'b0, 0);

      // Randomized mix of everything except HALT, with random fetch stalls.
      for (int n = 0; n < 60; n++) begin
         op = 4'($urandom_range(0, 14));
         ir = {op, 10'($urandom)};
         run_instr($sformatf("rnd%0d_op%0h", n, op), ir, 1'($urandom), int'($urandom_range(0, 3)));
      end

      // SUB aborted by reset during EXEC: no write, back to FETCH, counter cleared.
      ir = 14'h0400 | (14'd5 << 7) | (14'd6 << 4) | (14'd1 << 1);
      plan(ir, 1'b0);
      instruction_register = ir;
      for (int i = 0; i < 4; i++) begin
         imem_ack = (i == 0) ? 1'b1 : 1'b0;
         cyc($sformatf("sub/c%0d", i), exp_q[i]);
      end
      reset_n = 1'b0;
      cyc("sub_abort_in_reset", V_ZERO);
      reset_n = 1'b1;
      model_cnt = '0;
      cyc("sub_abort_fetch", V_IDLE);

      // Counter wrap: 2^CNT_W NOPs bring the count back to zero.
      for (int n = 0; n < (1 << TB_CNT_W); n++) begin
         op = 4'($urandom_range(10, 14));
         ir = {op, 10'($urandom)};
         run_instr("nop", ir, 1'($urandom), 0);
      end
      cyc("wrap_fetch", V_IDLE);

      // HALT: terminal, no enables, ack ignored; counter does not move.
      run_instr("halt", 14'h3C00, 1'b0, 0);
      for (int i = 0; i < 20; i++) begin
         imem_ack = 1'($urandom);
         a_zero = 1'($urandom);
         cyc("halted", V_HALT);
      end
      imem_ack = 1'b0;
      reset_n = 1'b0;
      cyc("halt_in_reset", V_ZERO);
      reset_n = 1'b1;
      model_cnt = '0;
      cyc("halt_released", V_IDLE);
      run_instr("post_halt_li", 14'h2101, 1'b0, 0);
      cyc("post_halt_fetch", V_IDLE);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/cpu_control_sequencer.md
Name: cpu_control_sequencer

Overview:
- Multicycle control FSM for the 8-bit common-bus CPU.
- Consumes the 14-bit instruction_register value and drives the datapath enables: PC load, IR load, register-file read/write, A/B/result latches, ALU op and bus source select.
- Sits directly upstream of the program counter, instruction register, register file and ALU, and sequences fetch, decode, execute and writeback over the single shared bus.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- instruction_register  in  14  current IR contents.
- imem_ack  in  1  instruction memory has valid data on instruction bus this cycle.
- a_zero  in  1  operand latch A equals 8'd0.
- imem_req  out  1  instruction fetch request.
- ir_load_en  out  1  IR load enable.
- pc_load_en  out  1  PC load enable.
- pc_sel  out  1  0 = pc+1, 1 = branch target (datapath computes pc + sext(off7)).
- rf_write_read  out  1  register file write enable.
- rf_address  out  8  register file address; bits [7:3] always 0.
- a_load_en, b_load_en, res_load_en  out  1 each  operand A, operand B and ALU result latch enables.
- alu_op  out  3  alu_op_t value.
- bus_sel  out  2  bus source: 0 = rf r_data, 1 = result latch, 2 = imm_out.
- imm_out  out  8  {1'b0, instruction_register[6:0]}.
- halted  out  1  core is halted.
- retired_count  out  CNT_W  count of instructions retired.

Behaviour:
- Reset is synchronous, active-low: clock, and reset_n is sampled only on the rising edge.
- While reset is asserted, the next edge sets state = FETCH and retired_count = 0.
- All enables, imem_req and halted are 0 in reset.
- alu_op defaults to A_PLUS_B (0), bus_sel to 0 and rf_address to 0 in every state where they are not specified below.
- Encoding:
  - opcode = IR[13:10], rd = IR[9:7], rs = IR[6:4], rt = IR[3:1], imm7/off7 = IR[6:0].
  - Opcodes 0x0-0x7: R-type ALU, alu_op = opcode[2:0] (A_PLUS_B=0 … A_SRA_B=7).
  - 0x8 = LI rd, imm7.
  - 0x9 = BEQZ rs, off7.
  - 0xF = HALT.
  - 0xA-0xE = NOP.
- States, with registered state and Moore outputs unless noted:
  - FETCH: imem_req=1; ir_load_en = imem_ack (Mealy). Stays in FETCH until imem_ack, then goes to DECODE.
  - DECODE: pc_load_en=1, pc_sel=0. ALU or BEQZ goes to READ_A; LI goes to WRITE_IMM; HALT goes to HALT; NOP goes to FETCH and retires.
  - READ_A: rf_address=rs, bus_sel=0, a_load_en=1. ALU goes to READ_B; BEQZ goes to BRANCH.
  - READ_B: rf_address=rt, bus_sel=0, b_load_en=1; goes to EXEC.
  - EXEC: alu_op=opcode[2:0], res_load_en=1; goes to WRITE.
  - WRITE: rf_address=rd, bus_sel=1, rf_write_read=1; goes to FETCH and retires.
  - WRITE_IMM: rf_address=rd, bus_sel=2, rf_write_read=1; goes to FETCH and retires.
  - BRANCH: pc_load_en=a_zero, pc_sel=1; goes to FETCH and retires.
  - HALT: halted=1, all enables 0. Terminal; exits only on reset.
- Latencies, counted from fetch ack to the next FETCH:
  - ALU: 6 cycles.
  - LI: 3 cycles.
  - BEQZ: 4 cycles.
  - NOP: 2 cycles.
- imem_ack is ignored outside FETCH. A stalled FETCH holds imem_req high indefinitely.
- The IR is sampled only in DECODE and later states; the IR value is stable after ir_load_en.
- retired_count increments by 1 on each retire transition and wraps modulo 2^CNT_W. It does not increment on HALT.
- Reset asserted mid-instruction aborts it:
  - No rf write in the reset cycle.
  - Returns to FETCH.
  - halted clears.
- Only one of a_load_en, b_load_en, res_load_en, rf_write_read, ir_load_en is high in any cycle.

Test Plan:
- Reset, then imem_ack held 0 for 5 cycles: imem_req=1 throughout, ir_load_en=0, state stays FETCH, retired_count=0.
- IR=0x0000|rd=3,rs=1,rt=2 (ADD), ack on first FETCH cycle:
  - READ_A has rf_address=1, a_load_en=1.
  - READ_B has rf_address=2.
  - EXEC has alu_op=0, res_load_en=1.
  - WRITE has rf_address=3, bus_sel=1, rf_write_read=1.
  - retired_count=1 after 6 cycles.
- LI rd=7, imm7=0x55 (IR=0x23D5): imm_out=0x55, WRITE_IMM has rf_address=7, bus_sel=2; 3 cycles total.
- BEQZ with a_zero=1, then repeated with a_zero=0: BRANCH has pc_load_en=1, pc_sel=1 in the first case and pc_load_en=0 in the second; both retire.
- HALT (IR=0x3C00): halted=1 from the cycle after DECODE; no enables for 20 cycles; reset_n=0 for one edge returns to FETCH with halted=0.
- retired_count at 0xFFFF plus one NOP goes to 0x0000. reset_n=0 during EXEC of SUB gives no rf_write_read and the FETCH state on the next cycle.
